iir_fb_combiner: RTL and testbench



---
 rtl/iir_pkg.sv | 14 +
 rtl/iir_fb_combiner_if.sv | 12 +
 rtl/iir_round_sat.sv | 27 ++
 rtl/iir_fb_combiner.sv | 101 ++++++++++
 tb/tb_iir_fb_combiner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, mode encodings, FSM states and sample limits for the IIR output stage.
package iir_pkg;
   localparam int ACC_W = 48;
   localparam int SMP_W = 32;
   localparam logic [1:0] EN_IDLE   = 2'b00;
   localparam logic [1:0] EN_RUN    = 2'b01;
   localparam logic [1:0] EN_BYPASS = 2'b10;
   localparam logic [1:0] EN_HOLD   = 2'b11;
   localparam logic signed [SMP_W-1:0] SMP_MAX = 32'sh7fff_ffff;
   localparam logic signed [SMP_W-1:0] SMP_MIN = 32'sh8000_0000;
   typedef enum logic [2:0] {
      ST_IDLE, ST_FLUSH, ST_WARMUP, ST_RUN, ST_BYPASS, ST_HOLD
   } state_t;
endpackage

// File: rtl/iir_fb_combiner_if.sv
// iir_fb_combiner_if: section sums in, registered output and pole feedback out.
interface iir_fb_combiner_if;
   import iir_pkg::*;
   logic                    in_valid;
   logic signed [ACC_W-1:0] zero_sum;
   logic signed [ACC_W-1:0] pole_sum;
   logic signed [SMP_W-1:0] y_fb;
   logic signed [SMP_W-1:0] y_out;
   logic                    out_valid;
   modport master (output in_valid, zero_sum, pole_sum, input y_fb, y_out, out_valid);
   modport slave  (input in_valid, zero_sum, pole_sum, output y_fb, y_out, out_valid);
endinterface

// File: rtl/iir_round_sat.sv
// iir_round_sat: arithmetic right shift by FRAC_BITS then saturate to OUT_W.
// IIR_FB_ROUND_EN defined: round-half-up before the shift; undefined: floor.
module iir_round_sat #(
   parameter int IN_W      = 49,
   parameter int FRAC_BITS = 10,
   parameter int OUT_W     = 32
) (
   input  logic signed [IN_W-1:0]  d,
   output logic signed [OUT_W-1:0] y,
   output logic                    sat
);
   typedef logic signed [IN_W:0] wide_t;
   localparam wide_t MAXV = (wide_t'(1) <<< (OUT_W-1)) - wide_t'(1);
   localparam wide_t MINV = -(wide_t'(1) <<< (OUT_W-1));
   wide_t r;
   logic  hi, lo;
`ifdef IIR_FB_ROUND_EN
   localparam wide_t HALF = wide_t'(1) <<< (FRAC_BITS-1);
   assign r = (wide_t'(d) + HALF) >>> FRAC_BITS;
`else
   assign r = wide_t'(d) >>> FRAC_BITS;
`endif
   assign hi  = r > MAXV;
   assign lo  = r < MINV;
   assign sat = hi | lo;
   assign y   = hi ? {1'b0, {(OUT_W-1){1'b1}}} : lo ? {1'b1, {(OUT_W-1){1'b0}}} : r[OUT_W-1:0];
endmodule

// File: rtl/iir_fb_combiner.sv
// iir_fb_combiner: IIR output stage, (zero_sum - pole_sum) rescaled, saturated and registered as y_out / y_fb.
// Mode FSM flushes feedback history and masks warm-up samples. Define IIR_FB_ROUND_EN for round-half-up.
module iir_fb_combiner
   import iir_pkg::*;
#(
   parameter int FRAC_BITS      = 10,
   parameter int FLUSH_CYCLES   = 7,
   parameter int WARMUP_SAMPLES = 8,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       en,
   input  logic             clr_sat,
   iir_fb_combiner_if.slave bus,
   output logic             sat_flag,
   output logic [CNT_W-1:0] sat_cnt,
   output logic [2:0]       state_o
);
   localparam int FW = $clog2(FLUSH_CYCLES+1);
   localparam int WW = $clog2(WARMUP_SAMPLES+1);
   state_t                  st, nxt;
   logic [FW-1:0]           fcnt;
   logic [WW-1:0]           wcnt;
   logic signed [ACC_W:0]   d;
   logic signed [ACC_W-1:0] ps;
   logic signed [SMP_W-1:0] y_reg, rs;
   logic                    v1, v2, sat, active;

   iir_round_sat #(.IN_W(ACC_W+1), .FRAC_BITS(FRAC_BITS), .OUT_W(SMP_W)) u_rs (
      .d(d), .y(rs), .sat(sat)
   );

   always_ff @(posedge clk)
      st <= !rst_n ? ST_IDLE : nxt;

   always_comb begin
      nxt = st;
      unique case (st)
         ST_IDLE:   nxt = (en == EN_RUN || en == EN_BYPASS) ? ST_FLUSH : ST_IDLE;
         ST_FLUSH:  nxt = en == EN_IDLE ? ST_IDLE : fcnt != '0 ? ST_FLUSH :
                          en == EN_BYPASS ? ST_BYPASS : ST_WARMUP;
         ST_WARMUP: nxt = en == EN_IDLE ? ST_IDLE : en == EN_BYPASS ? ST_FLUSH :
                          (v2 && wcnt == WW'(WARMUP_SAMPLES-1)) ? ST_RUN : ST_WARMUP;
         ST_RUN:    nxt = en == EN_IDLE ? ST_IDLE : en == EN_HOLD ? ST_HOLD :
                          en == EN_BYPASS ? ST_FLUSH : ST_RUN;
         ST_BYPASS: nxt = en == EN_IDLE ? ST_IDLE : en == EN_RUN ? ST_FLUSH : ST_BYPASS;
         ST_HOLD:   nxt = en == EN_IDLE ? ST_IDLE : en == EN_RUN ? ST_RUN : ST_HOLD;
         default:   nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      active        = st inside {ST_WARMUP, ST_RUN, ST_BYPASS};
      ps            = st == ST_BYPASS ? '0 : bus.pole_sum;
      bus.y_out     = st == ST_IDLE ? '0 : y_reg;
      bus.y_fb      = st inside {ST_IDLE, ST_FLUSH, ST_BYPASS} ? '0 : y_reg;
      bus.out_valid = v2 && (st == ST_RUN || st == ST_BYPASS);
      state_o       = st;
   end

   // flush length counts down from entry; warm-up counts completed samples
   always_ff @(posedge clk)
      if (!rst_n) begin
         fcnt <= '0;
         wcnt <= '0;
      end else begin
         fcnt <= (nxt == ST_FLUSH && st != ST_FLUSH) ? FW'(FLUSH_CYCLES-1) :
                 st == ST_FLUSH ? fcnt - FW'(1) : fcnt;
         wcnt <= st != ST_WARMUP ? '0 : wcnt + WW'(v2);
      end

   // HOLD freezes data but drops v2 so a sample is never reported twice on resume
   always_ff @(posedge clk)
      if (!rst_n) begin
         d     <= '0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         y_reg <= '0;
      end else if (st == ST_HOLD) begin
         v2 <= 1'b0;
      end else if (active) begin
         v1 <= bus.in_valid;
         if (bus.in_valid) d <= (ACC_W+1)'(bus.zero_sum) - (ACC_W+1)'(ps);
         v2 <= v1;
         if (v1) y_reg <= rs;
      end else begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         y_reg <= '0;
      end

   always_ff @(posedge clk)
      if (!rst_n || clr_sat) begin
         sat_flag <= 1'b0;
         sat_cnt  <= '0;
      end else if (active && v1 && sat) begin
         sat_flag <= 1'b1;
         sat_cnt  <= &sat_cnt ? sat_cnt : sat_cnt + CNT_W'(1);
      end
endmodule

// File: tb/tb_iir_fb_combiner.sv
// tb_iir_fb_combiner: directed vector table plus hand-written mode/flush/hold/reset sequences.
module tb_iir_fb_combiner;
   import iir_pkg::*;
`ifdef IIR_FB_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   localparam longint L41 = 64'sd1 <<< 41;

   typedef struct {
      logic signed [47:0] z;
      logic signed [47:0] p;
      logic signed [31:0] y;
      logic               f;
      int                 c;
   } vec_t;

   logic        clk, rst_n, clr_sat, sat_flag;
   logic [1:0]  en;
   logic [15:0] sat_cnt;
   logic [2:0]  state_o;
   int          tests, fails;
   vec_t        vt[12];

   iir_fb_combiner_if bus();

   iir_fb_combiner dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr_sat(clr_sat), .bus(bus),
      .sat_flag(sat_flag), .sat_cnt(sat_cnt), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] e, input logic iv, input logic signed [47:0] z, input logic signed [47:0] p);
      en           = e;
      bus.in_valid = iv;
      bus.zero_sum = z;
      bus.pole_sum = p;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [1:0] e, input logic signed [47:0] z, input logic signed [47:0] p);
      step(e, 1'b1, z, p);
      step(e, 1'b0, '0, '0);
   endtask

   task automatic flush_len(input logic [1:0] e);
      int n, bad;
      n = 0;
      bad = 0;
      while (state_o == ST_FLUSH && n < 20) begin
         if (bus.y_fb !== 32'sd0) bad++;
         n++;
         step(e, 1'b0, '0, '0);
      end
      check("flush y_fb zero", 64'(bad), 64'(0));
      check("flush length", 64'(n), 64'(7));
   endtask

   task automatic warmup();
      int n, bad;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step(EN_RUN, 1'b1, '0, '0);
         bad += int'(bus.out_valid);
      end
      n = 0;
      while (state_o != ST_RUN && n < 10) begin
         step(EN_RUN, 1'b0, '0, '0);
         bad += int'(bus.out_valid);
         n++;
      end
      check("warmup out_valid masked", 64'(bad), 64'(0));
      check("warmup drain cycles", 64'(n), 64'(2));
      check("warmup -> RUN", 64'(state_o), 64'(ST_RUN));
   endtask

   task automatic go_run();
      step(EN_RUN, 1'b0, '0, '0);
      check("enter FLUSH", 64'(state_o), 64'(ST_FLUSH));
      flush_len(EN_RUN);
      check("flush -> WARMUP", 64'(state_o), 64'(ST_WARMUP));
      warmup();
   endtask

   initial begin
      int bad;
      tests = 0;
      fails = 0;
      vt[0]  = '{48'sd5120, 48'sd1024, 32'sd4, 1'b0, 0};
      vt[1]  = '{48'sd1536, 48'sd0, RND ? 32'sd2 : 32'sd1, 1'b0, 0};
      vt[2]  = '{-48'sd1536, 48'sd0, RND ? -32'sd1 : -32'sd2, 1'b0, 0};
      vt[3]  = '{48'sd512, 48'sd0, RND ? 32'sd1 : 32'sd0, 1'b0, 0};
      vt[4]  = '{-48'sd512, 48'sd0, RND ? 32'sd0 : -32'sd1, 1'b0, 0};
      vt[5]  = '{48'sd0, 48'sd3072, -32'sd3, 1'b0, 0};
      vt[6]  = '{48'(L41 - 1024), 48'sd0, SMP_MAX, 1'b0, 0};
      vt[7]  = '{48'(-L41), 48'sd0, SMP_MIN, 1'b0, 0};
      vt[8]  = '{48'(L41), 48'sd0, SMP_MAX, 1'b1, 1};
      vt[9]  = '{48'(-L41 - 2048), 48'sd0, SMP_MIN, 1'b1, 2};
      vt[10] = '{48'sh7fff_ffff_ffff, 48'sh8000_0000_0000, SMP_MAX, 1'b1, 3};
      vt[11] = '{48'sd102400, 48'sd0, 32'sd100, 1'b1, 3};

      rst_n   = 1'b0;
      clr_sat = 1'b0;
      step(EN_IDLE, 1'b1, 48'sd5120, '0);
      step(EN_IDLE, 1'b1, 48'sd5120, '0);
      check("reset y_out", 64'(bus.y_out), 64'(0));
      check("reset y_fb", 64'(bus.y_fb), 64'(0));
      check("reset out_valid", 64'(bus.out_valid), 64'(0));
      check("reset sat_flag", 64'(sat_flag), 64'(0));
      check("reset sat_cnt", 64'(sat_cnt), 64'(0));
      check("reset state", 64'(state_o), 64'(ST_IDLE));
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step(EN_IDLE, 1'b1, 48'sd5120, '0);
         if (bus.out_valid !== 1'b0 || bus.y_out !== 32'sd0 || state_o !== 3'(ST_IDLE)) bad++;
      end
      check("idle ignores samples", 64'(bad), 64'(0));

      go_run();
      for (int i = 0; i < 12; i++) begin
         sample(EN_RUN, vt[i].z, vt[i].p);
         check($sformatf("v%0d y_out", i), 64'(bus.y_out), 64'(vt[i].y));
         check($sformatf("v%0d y_fb", i), 64'(bus.y_fb), 64'(vt[i].y));
         check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(1));
         check($sformatf("v%0d sat_flag", i), 64'(sat_flag), 64'(vt[i].f));
         check($sformatf("v%0d sat_cnt", i), 64'(sat_cnt), 64'(vt[i].c));
      end

      clr_sat = 1'b1;
      sample(EN_RUN, 48'(L41), '0);
      clr_sat = 1'b0;
      check("clr y_out", 64'(bus.y_out), 64'(SMP_MAX));
      check("clr sat_flag", 64'(sat_flag), 64'(0));
      check("clr sat_cnt", 64'(sat_cnt), 64'(0));
      sample(EN_RUN, 48'(L41), '0);
      check("post-clr sat_cnt", 64'(sat_cnt), 64'(1));
      check("post-clr sat_flag", 64'(sat_flag), 64'(1));

      sample(EN_RUN, 48'sd102400, '0);
      check("pre-flush y_fb", 64'(bus.y_fb), 64'(100));
      step(EN_BYPASS, 1'b0, '0, '0);
      check("reflush state", 64'(state_o), 64'(ST_FLUSH));
      flush_len(EN_BYPASS);
      check("flush -> BYPASS", 64'(state_o), 64'(ST_BYPASS));
      sample(EN_BYPASS, 48'sd2048, 48'sd99999);
      check("bypass y_out", 64'(bus.y_out), 64'(2));
      check("bypass y_fb", 64'(bus.y_fb), 64'(0));
      check("bypass out_valid", 64'(bus.out_valid), 64'(1));

      go_run();
      sample(EN_RUN, 48'sd102400, '0);
      check("pre-hold y_out", 64'(bus.y_out), 64'(100));
      step(EN_HOLD, 1'b0, '0, '0);
      check("hold state", 64'(state_o), 64'(ST_HOLD));
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step(EN_HOLD, 1'(i % 2), 48'sd1022976, '0);
         if (bus.y_out !== 32'sd100 || bus.y_fb !== 32'sd100 || bus.out_valid !== 1'b0 ||
             state_o !== 3'(ST_HOLD)) bad++;
      end
      check("hold frozen", 64'(bad), 64'(0));
      step(EN_RUN, 1'b0, '0, '0);
      check("hold -> RUN no flush", 64'(state_o), 64'(ST_RUN));
      sample(EN_RUN, 48'sd7168, '0);
      check("resume y_out", 64'(bus.y_out), 64'(7));
      check("resume y_fb", 64'(bus.y_fb), 64'(7));
      check("resume out_valid", 64'(bus.out_valid), 64'(1));

      step(EN_RUN, 1'b1, 48'sd5120, '0);
      step(EN_RUN, 1'b1, 48'sd6144, '0);
      rst_n = 1'b0;
      step(EN_RUN, 1'b1, 48'sd7168, '0);
      check("midreset y_out", 64'(bus.y_out), 64'(0));
      check("midreset y_fb", 64'(bus.y_fb), 64'(0));
      check("midreset out_valid", 64'(bus.out_valid), 64'(0));
      check("midreset state", 64'(state_o), 64'(ST_IDLE));
      check("midreset sat_cnt", 64'(sat_cnt), 64'(0));
      check("midreset sat_flag", 64'(sat_flag), 64'(0));
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step(EN_IDLE, 1'b0, '0, '0);
         if (bus.out_valid !== 1'b0 || bus.y_out !== 32'sd0) bad++;
      end
      check("midreset no stale valid", 64'(bad), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
